drift_event_packer: RTL

- Per-event drift-time digitiser and packer for the drift-tube readout.
- Arms on a scintillator coincidence trigger and opens a fixed time window. Within that window it captures the first hit time on each of NUM_CH tube channels.
- After the window closes, it streams header, per-channel data and trailer words into the 16-bit event FIFO write port (din / wr_en / full) that feeds the RPi reader.
- It replaces ad-hoc per-tube counters and a fixed-schedule write sequence with one backpressure-aware stage.

---
 rtl/drift_pkg.sv | 36 +++
 rtl/hit_capture_ch.sv | 39 +++
 rtl/drift_event_packer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/drift_pkg.sv
// Shared constants, state encoding and word formats for the drift-tube event packer.
package drift_pkg;

    localparam int unsigned TIME_W = 8;
    localparam int unsigned CH_W   = 5;
    localparam int unsigned WORD_W = 16;

    localparam logic [TIME_W-1:0] HDR_TAG      = 8'hAA;
    localparam logic [2:0]        DATA_TAG     = 3'b010;
    localparam logic [WORD_W-1:0] TRAILER_WORD = 16'hFFFF;
    localparam logic [TIME_W-1:0] NO_HIT       = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WINDOW,
        ST_HEADER,
        ST_DATA,
        ST_TRAILER
    } state_t;

    typedef struct packed {
        logic [TIME_W-1:0] hit_time;
        logic [2:0]        tag;
        logic [CH_W-1:0]   ch;
    } data_word_t;

    function automatic logic [WORD_W-1:0] data_word(input logic [TIME_W-1:0] hit_time,
                                                    input logic [CH_W-1:0]   ch);
        data_word_t w;
        w.hit_time = hit_time;
        w.tag      = DATA_TAG;
        w.ch       = ch;
        return w;
    endfunction

endpackage

// File: rtl/hit_capture_ch.sv
// One tube channel: input synchroniser, rising-edge detector and first-hit time register.
module hit_capture_ch
    import drift_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk100,
    input  logic              rst,
    input  logic              hit_async,
    input  logic              clear,
    input  logic              active,
    input  logic [TIME_W-1:0] cnt,
    output logic [TIME_W-1:0] hit_time
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic                   rise_c;

    assign rise_c = sync[SYNC_STAGES-1] & ~prev;

    // Edge detection runs every cycle so a level already high at window start never counts.
    always_ff @(posedge clk100) begin
        if (rst) begin
            sync     <= '0;
            prev     <= 1'b0;
            hit_time <= NO_HIT;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], hit_async};
            prev <= sync[SYNC_STAGES-1];
            if (clear) begin
                hit_time <= NO_HIT;
            end else if (active && rise_c && (hit_time == NO_HIT)) begin
                hit_time <= cnt;
            end
        end
    end

endmodule

// File: rtl/drift_event_packer.sv
// Trigger-armed drift-time window: captures first hit per channel, then streams
// header / per-channel data / trailer words into the event FIFO with backpressure.
module drift_event_packer
    import drift_pkg::*;
#(
    parameter int unsigned NUM_CH      = 32,
    parameter int unsigned WINDOW      = 255,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk100,
    input  logic              rst,
    input  logic              trig,
    input  logic [NUM_CH-1:0] hit,
    output logic [WORD_W-1:0] din,
    output logic              wr_en,
    input  logic              full,
    output logic              busy,
    output logic              trig_lost,
    output logic [7:0]        evt_id
);

    localparam logic [TIME_W-1:0] LAST_CNT = TIME_W'(WINDOW - 1);
    localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NUM_CH - 1);

    state_t               state, state_nxt;
    logic [TIME_W-1:0]    cnt, cnt_nxt;
    logic [CH_W-1:0]      ch_idx, ch_nxt;
    logic [WORD_W-1:0]    din_nxt;
    logic                 wr_en_nxt, busy_nxt, trig_lost_nxt;
    logic [7:0]           evt_id_nxt;
    logic [SYNC_STAGES-1:0] trig_sync;
    logic                 trig_prev;
    logic                 trig_rise_c, clear_c, window_c;
    logic [TIME_W-1:0]    hit_time [NUM_CH];

    assign trig_rise_c = trig_sync[SYNC_STAGES-1] & ~trig_prev;
    assign clear_c     = (state == ST_IDLE) && trig_rise_c;
    assign window_c    = (state == ST_WINDOW);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        hit_capture_ch #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_cap (
            .clk100    (clk100),
            .rst       (rst),
            .hit_async (hit[i]),
            .clear     (clear_c),
            .active    (window_c),
            .cnt       (cnt),
            .hit_time  (hit_time[i])
        );
    end

    // Trigger synchroniser and previous-value flop for edge detection.
    always_ff @(posedge clk100) begin
        if (rst) begin
            trig_sync <= '0;
            trig_prev <= 1'b0;
        end else begin
            trig_sync <= {trig_sync[SYNC_STAGES-2:0], trig};
            trig_prev <= trig_sync[SYNC_STAGES-1];
        end
    end

    // State and registered datapath/outputs.
    always_ff @(posedge clk100) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            ch_idx    <= '0;
            din       <= '0;
            wr_en     <= 1'b0;
            busy      <= 1'b0;
            trig_lost <= 1'b0;
            evt_id    <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            ch_idx    <= ch_nxt;
            din       <= din_nxt;
            wr_en     <= wr_en_nxt;
            busy      <= busy_nxt;
            trig_lost <= trig_lost_nxt;
            evt_id    <= evt_id_nxt;
        end
    end

    // Next state: each write state advances only when the FIFO is not full.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:    if (trig_rise_c) state_nxt = ST_WINDOW;
            ST_WINDOW:  if (cnt == LAST_CNT) state_nxt = ST_HEADER;
            ST_HEADER:  if (!full) state_nxt = ST_DATA;
            ST_DATA:    if (!full && (ch_idx == LAST_CH)) state_nxt = ST_TRAILER;
            ST_TRAILER: if (!full) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Output and datapath next values; din keeps presenting the pending word while stalled.
    always_comb begin
        cnt_nxt       = cnt;
        ch_nxt        = ch_idx;
        din_nxt       = din;
        wr_en_nxt     = 1'b0;
        evt_id_nxt    = evt_id;
        busy_nxt      = (state_nxt != ST_IDLE);
        trig_lost_nxt = trig_rise_c && (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                ch_nxt  = '0;
            end
            ST_WINDOW: begin
                cnt_nxt = cnt + 8'd1;
            end
            ST_HEADER: begin
                din_nxt   = {HDR_TAG, evt_id};
                wr_en_nxt = !full;
            end
            ST_DATA: begin
                din_nxt   = data_word(hit_time[ch_idx], ch_idx);
                wr_en_nxt = !full;
                if (!full) ch_nxt = ch_idx + 5'd1;
            end
            ST_TRAILER: begin
                din_nxt   = TRAILER_WORD;
                wr_en_nxt = !full;
                if (!full) evt_id_nxt = evt_id + 8'd1;
            end
            default: begin
                cnt_nxt = '0;
            end
        endcase
    end

endmodule
